// File: rtl/euler_integrator_mc_if.sv
// euler_integrator_mc_if: host control and derivative-unit bus for the multi-channel Euler integrator
interface euler_integrator_mc_if #(
  parameter int WIDTH = 18,
  parameter int NCH = 3,
  parameter int DTW = 4,
  parameter int STEPW = 16,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [DTW-1:0] dt;
  logic init_we;
  logic [CHW-1:0] init_ch;
  logic [WIDTH-1:0] init_val;
  logic start;
  logic [STEPW-1:0] nsteps;
  logic func_req;
  logic func_valid;
  logic [NCH*WIDTH-1:0] func_flat;
  logic [NCH*WIDTH-1:0] x_flat;
  logic busy;
  logic done;
  logic [STEPW-1:0] step_count;
  logic sat_flag;
  modport master (
    output dt, init_we, init_ch, init_val, start, nsteps, func_valid, func_flat,
    input func_req, x_flat, busy, done, step_count, sat_flag
  );
  modport slave (
    input dt, init_we, init_ch, init_val, start, nsteps, func_valid, func_flat,
    output func_req, x_flat, busy, done, step_count, sat_flag
  );
endinterface

// File: rtl/euler_integrator_mc.sv
// euler_integrator_mc: NCH-channel fixed-point Euler integrator, one shared adder, derivatives via req/valid.
// Define INTEG_SAT_EN to clamp updates and raise a sticky sat_flag; otherwise results wrap.
module euler_integrator_mc #(
  parameter int WIDTH = 18,
  parameter int FRAC = 16,
  parameter int NCH = 3,
  parameter int DTW = 4,
  parameter int STEPW = 16
) (
  input logic clock,
  input logic reset,
  euler_integrator_mc_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, REQ, UPD, DONE} state_t;
  state_t r_state, w_next;
  logic signed [WIDTH-1:0] r_x [NCH];
  logic signed [WIDTH-1:0] r_f [NCH];
  logic [CHW-1:0] r_ch;
  logic [STEPW-1:0] r_nsteps, r_step, w_step_inc;
  logic signed [WIDTH-1:0] w_sh, w_new;
  logic w_last, w_init_ok, w_req, w_busy, w_done;
  generate
    if (NCH < 1 || FRAC < 0 || FRAC > WIDTH) begin : g_bad_cfg
      $error("euler_integrator_mc: invalid NCH/FRAC");
    end
  endgenerate
  assign w_sh = r_f[r_ch] >>> bus.dt;
`ifdef INTEG_SAT_EN
  logic signed [WIDTH:0] w_sum;
  logic w_clamp, r_sat;
  assign w_sum = {r_x[r_ch][WIDTH-1], r_x[r_ch]} + {w_sh[WIDTH-1], w_sh};
  // top two bits disagree only when the WIDTH+1 sum left the WIDTH range
  assign w_clamp = w_sum[WIDTH] != w_sum[WIDTH-1];
  assign w_new = w_clamp ? {w_sum[WIDTH], {(WIDTH-1){~w_sum[WIDTH]}}} : w_sum[WIDTH-1:0];
  always_ff @(posedge clock)
    r_sat <= (reset || (r_state == IDLE && bus.start)) ? 1'b0 : (r_sat || (r_state == UPD && w_clamp));
  assign bus.sat_flag = r_sat;
`else
  assign w_new = r_x[r_ch] + w_sh;
  assign bus.sat_flag = 1'b0;
`endif
  assign w_last = r_ch == CHW'(NCH - 1);
  assign w_step_inc = r_step + 1'b1;
  assign w_init_ok = {1'b0, bus.init_ch} < (CHW + 1)'(NCH);
  always_ff @(posedge clock)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_req = 1'b0;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        w_next = !bus.start ? IDLE : (bus.nsteps == '0) ? DONE : REQ;
      end
      REQ: begin
        w_req = 1'b1;
        w_next = bus.func_valid ? UPD : REQ;
      end
      UPD: w_next = !w_last ? UPD : (w_step_inc == r_nsteps) ? DONE : REQ;
      default: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  assign bus.func_req = w_req;
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.step_count = r_step;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        r_x[k] <= '0;
        r_f[k] <= '0;
      end
      r_ch <= '0;
      r_nsteps <= '0;
      r_step <= '0;
    end else begin
      if (r_state == IDLE && bus.init_we && w_init_ok)
        r_x[bus.init_ch] <= bus.init_val;
      if (r_state == IDLE && bus.start) begin
        r_nsteps <= bus.nsteps;
        r_step <= '0;
      end
      if (r_state == REQ && bus.func_valid) begin
        for (int k = 0; k < NCH; k++)
          r_f[k] <= bus.func_flat[k*WIDTH +: WIDTH];
        r_ch <= '0;
      end
      if (r_state == UPD) begin
        r_x[r_ch] <= w_new;
        r_ch <= w_last ? '0 : r_ch + 1'b1;
        if (w_last)
          r_step <= w_step_inc;
      end
    end
  end
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_flat
      assign bus.x_flat[i*WIDTH +: WIDTH] = r_x[i];
    end
  endgenerate
endmodule

// File: tb/tb_euler_integrator_mc.sv
// tb_euler_integrator_mc: randomized self-checking bench with a floor-division reference model.
module tb_euler_integrator_mc;
  localparam int W = 18;
  localparam int N = 3;
  localparam int SW = 16;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));
`ifdef INTEG_SAT_EN
  localparam logic [W-1:0] EXP_SAT_X = 18'h1FFFF;
  localparam logic EXP_SAT_F = 1'b1;
`else
  localparam logic [W-1:0] EXP_SAT_X = 18'h3FFFE;
  localparam logic EXP_SAT_F = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  euler_integrator_mc_if bus ();
  euler_integrator_mc dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int n_tests = 0;
  int n_fail = 0;
  longint m_x [N];
  bit m_sat;
  bit use_fixed;
  logic [W-1:0] fixed_f [N];
  int req_rises = 0;
  int done_cnt = 0;
  logic prev_req = 1'b0;
  always @(posedge clock) begin
    if (bus.func_req && !prev_req) req_rises++;
    if (bus.done) done_cnt++;
    prev_req = bus.func_req;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = v;
    return s;
  endfunction

  // x += floor(f / 2^d), then clamp or wrap into W-bit two's complement
  function automatic void model_upd(input int c, input longint f, input int d);
    longint p, q, s;
    p = longint'(1) << d;
    q = (f >= 0) ? f / p : -((-f + p - 1) / p);
    s = m_x[c] + q;
`ifdef INTEG_SAT_EN
    if (s > MAXV) begin s = MAXV; m_sat = 1; end
    else if (s < MINV) begin s = MINV; m_sat = 1; end
`else
    s = ((s - MINV + (longint'(1) << W)) % (longint'(1) << W)) + MINV;
`endif
    m_x[c] = s;
  endfunction

  task automatic apply_reset();
    reset = 1;
    tick();
    reset = 0;
    for (int c = 0; c < N; c++) m_x[c] = 0;
    m_sat = 0;
  endtask

  task automatic do_init(input int ch, input logic [W-1:0] v);
    bus.init_we = 1;
    bus.init_ch = 2'(ch);
    bus.init_val = v;
    tick();
    bus.init_we = 0;
    if (ch < N) m_x[ch] = sx(v);
  endtask

  task automatic junk_on();
    bus.start = 1;
    bus.nsteps = 16'd99;
    bus.init_we = 1;
    bus.init_ch = 0;
    bus.init_val = 18'd1234;
  endtask

  task automatic junk_off();
    bus.start = 0;
    bus.init_we = 0;
  endtask

  task automatic send_f(input int d);
    logic [W-1:0] f;
    for (int c = 0; c < N; c++) begin
      f = use_fixed ? fixed_f[c] : W'($urandom);
      bus.func_flat[c*W +: W] = f;
      model_upd(c, sx(f), d);
    end
    bus.func_valid = 1;
  endtask

  task automatic run(input int ns, input int d, input int dlo, input int dhi, input bit inject,
                     input bit co_init, input logic [W-1:0] civ,
                     output bit ok, output int reqs, output int dones);
    int r0, d0, t;
    r0 = req_rises;
    d0 = done_cnt;
    ok = 1;
    bus.nsteps = SW'(ns);
    bus.dt = 4'(d);
    bus.start = 1;
    if (co_init) begin
      bus.init_we = 1;
      bus.init_ch = 0;
      bus.init_val = civ;
      m_x[0] = sx(civ);
    end
    tick();
    bus.start = 0;
    bus.init_we = 0;
    m_sat = 0;
    for (int s = 0; s < ns && ok; s++) begin
      t = 0;
      while (!bus.func_req && t < 40) begin tick(); t++; end
      if (!bus.func_req) ok = 0;
      else begin
        repeat ($urandom_range(dhi, dlo)) tick();
        if (inject) begin junk_on(); tick(); junk_off(); end
        send_f(d);
        tick();
        bus.func_valid = 0;
        bus.func_flat = (N*W)'({$urandom, $urandom});
        if (inject) begin junk_on(); tick(); junk_off(); end
      end
    end
    t = 0;
    while (ok && !bus.done && t < 40) begin tick(); t++; end
    if (!bus.done) ok = 0;
    tick();
    reqs = req_rises - r0;
    dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int c = 0; c < N; c++) m_x[c] = 0;
    n_tests++; if (bus.x_flat !== '0) begin n_fail++; $display("FAIL reset_x: got %h expected 0", bus.x_flat); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.func_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.func_req); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_tests++; if (bus.step_count !== '0) begin n_fail++; $display("FAIL reset_step: got %0d expected 0", bus.step_count); end
    n_tests++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", bus.sat_flag); end
  endtask

  task automatic test_single_step();
    bit ok;
    int reqs, dones;
    logic signed [W-1:0] g;
    logic signed [W-1:0] exp_x [N];
    apply_reset();
    do_init(1, 18'sd500);
    do_init(2, -18'sd700);
    use_fixed = 1;
    for (int c = 0; c < N; c++) fixed_f[c] = 18'h08000;
    run(1, 9, 0, 0, 0, 1, -18'sd32768, ok, reqs, dones);
    exp_x[0] = -18'sd32704;
    exp_x[1] = 18'sd564;
    exp_x[2] = -18'sd636;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: run did not complete"); end
    for (int c = 0; c < N; c++) begin
      g = bus.x_flat[c*W +: W];
      n_tests++; if (g !== exp_x[c]) begin n_fail++; $display("FAIL single_x%0d: got %0d expected %0d", c, g, exp_x[c]); end
    end
    n_tests++; if (bus.step_count !== 16'd1) begin n_fail++; $display("FAIL single_step: got %0d expected 1", bus.step_count); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL single_done: got %0d pulses expected 1", dones); end
    n_tests++; if (reqs !== 1) begin n_fail++; $display("FAIL single_reqs: got %0d expected 1", reqs); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_latency();
    int d, t;
    longint old_x [N];
    logic signed [W-1:0] g;
    apply_reset();
    for (int c = 0; c < N; c++) do_init(c, W'($urandom_range(2000, 0)));
    use_fixed = 0;
    d = $urandom_range(6, 0);
    bus.dt = 4'(d);
    bus.nsteps = 16'd2;
    bus.start = 1;
    tick();
    bus.start = 0;
    m_sat = 0;
    n_tests++; if (bus.func_req !== 1'b1) begin n_fail++; $display("FAIL lat_req_after_start: got %b expected 1", bus.func_req); end
    repeat (2) tick();
    for (int c = 0; c < N; c++) old_x[c] = m_x[c];
    send_f(d);
    tick();
    bus.func_valid = 0;
    g = bus.x_flat[0 +: W];
    n_tests++; if (g !== W'(old_x[0])) begin n_fail++; $display("FAIL lat_x0_early: got %0d expected %0d", g, old_x[0]); end
    tick();
    g = bus.x_flat[0 +: W];
    n_tests++; if (g !== W'(m_x[0])) begin n_fail++; $display("FAIL lat_x0_update: got %0d expected %0d", g, m_x[0]); end
    g = bus.x_flat[(N-1)*W +: W];
    n_tests++; if (g !== W'(old_x[N-1])) begin n_fail++; $display("FAIL lat_xlast_early: got %0d expected %0d", g, old_x[N-1]); end
    repeat (N - 1) tick();
    g = bus.x_flat[(N-1)*W +: W];
    n_tests++; if (g !== W'(m_x[N-1])) begin n_fail++; $display("FAIL lat_xlast_update: got %0d expected %0d", g, m_x[N-1]); end
    n_tests++; if (bus.func_req !== 1'b1) begin n_fail++; $display("FAIL lat_next_req: got %b expected 1", bus.func_req); end
    n_tests++; if (bus.step_count !== 16'd1) begin n_fail++; $display("FAIL lat_step1: got %0d expected 1", bus.step_count); end
    send_f(d);
    tick();
    bus.func_valid = 0;
    t = 0;
    while (!bus.done && t < 20) begin tick(); t++; end
    n_tests++; if (t !== N) begin n_fail++; $display("FAIL lat_done_delay: got %0d cycles expected %0d", t, N); end
    tick();
    n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL lat_done_width: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
    for (int c = 0; c < N; c++) begin
      g = bus.x_flat[c*W +: W];
      n_tests++; if (g !== W'(m_x[c])) begin n_fail++; $display("FAIL lat_final_x%0d: got %0d expected %0d", c, g, m_x[c]); end
    end
  endtask

  task automatic test_neg_deriv();
    bit ok;
    int reqs, dones;
    logic signed [W-1:0] g;
    apply_reset();
    use_fixed = 1;
    for (int c = 0; c < N; c++) fixed_f[c] = 18'h3FFFF;
    run(10, 4, 2, 2, 0, 0, '0, ok, reqs, dones);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL neg_timeout: run did not complete"); end
    for (int c = 0; c < N; c++) begin
      g = bus.x_flat[c*W +: W];
      n_tests++; if (g !== -18'sd10 || g !== W'(m_x[c])) begin n_fail++; $display("FAIL neg_x%0d: got %0d expected -10", c, g); end
    end
    n_tests++; if (reqs !== 10) begin n_fail++; $display("FAIL neg_reqs: got %0d expected 10", reqs); end
    n_tests++; if (bus.step_count !== 16'd10) begin n_fail++; $display("FAIL neg_step: got %0d expected 10", bus.step_count); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL neg_done: got %0d expected 1", dones); end
  endtask

  task automatic test_saturation();
    bit ok;
    int reqs, dones;
    logic signed [W-1:0] g;
    apply_reset();
    do_init(0, 18'sd77);
    do_init(1, 18'h1FFFF);
    use_fixed = 1;
    fixed_f[0] = '0;
    fixed_f[1] = 18'h1FFFF;
    fixed_f[2] = '0;
    run(1, 0, 0, 1, 0, 0, '0, ok, reqs, dones);
    g = bus.x_flat[W +: W];
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: run did not complete"); end
    n_tests++; if (g !== EXP_SAT_X || g !== W'(m_x[1])) begin n_fail++; $display("FAIL sat_x1: got %h expected %h", g, EXP_SAT_X); end
    n_tests++; if (bus.sat_flag !== EXP_SAT_F || bus.sat_flag !== m_sat) begin n_fail++; $display("FAIL sat_flag: got %b expected %b", bus.sat_flag, EXP_SAT_F); end
    g = bus.x_flat[0 +: W];
    n_tests++; if (g !== 18'sd77) begin n_fail++; $display("FAIL sat_x0: got %0d expected 77", g); end
    fixed_f[1] = '0;
    run(1, 0, 0, 0, 0, 0, '0, ok, reqs, dones);
    n_tests++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_cleared: got %b expected 0", bus.sat_flag); end
  endtask

  task automatic test_zero_steps();
    int r0, d0;
    logic signed [W-1:0] g;
    apply_reset();
    for (int c = 0; c < N; c++) do_init(c, W'($urandom));
    r0 = req_rises;
    d0 = done_cnt;
    bus.nsteps = '0;
    bus.start = 1;
    tick();
    bus.start = 0;
    n_tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b expected 1 1", bus.done, bus.busy); end
    tick();
    n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
    repeat (3) tick();
    n_tests++; if (req_rises - r0 !== 0) begin n_fail++; $display("FAIL zero_reqs: got %0d expected 0", req_rises - r0); end
    n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt - d0); end
    n_tests++; if (bus.step_count !== '0) begin n_fail++; $display("FAIL zero_step: got %0d expected 0", bus.step_count); end
    for (int c = 0; c < N; c++) begin
      g = bus.x_flat[c*W +: W];
      n_tests++; if (g !== W'(m_x[c])) begin n_fail++; $display("FAIL zero_x%0d: got %0d expected %0d", c, g, m_x[c]); end
    end
  endtask

  task automatic test_reset_midrun();
    int t, r0, d0;
    apply_reset();
    for (int c = 0; c < N; c++) do_init(c, W'($urandom));
    use_fixed = 0;
    bus.nsteps = 16'd5;
    bus.dt = 4'd2;
    bus.start = 1;
    tick();
    bus.start = 0;
    t = 0;
    while (!bus.func_req && t < 20) begin tick(); t++; end
    n_tests++; if (bus.func_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_timeout: got %b expected 1", bus.func_req); end
    send_f(2);
    tick();
    bus.func_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    for (int c = 0; c < N; c++) m_x[c] = 0;
    n_tests++; if (bus.x_flat !== '0) begin n_fail++; $display("FAIL mid_x: got %h expected 0", bus.x_flat); end
    n_tests++; if (bus.busy !== 1'b0 || bus.func_req !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl: got busy=%b req=%b expected 0 0", bus.busy, bus.func_req); end
    n_tests++; if (bus.step_count !== '0) begin n_fail++; $display("FAIL mid_step: got %0d expected 0", bus.step_count); end
    r0 = req_rises;
    d0 = done_cnt;
    repeat (10) tick();
    n_tests++; if (done_cnt !== d0 || req_rises !== r0) begin n_fail++; $display("FAIL mid_quiet: got done=%0d req=%0d expected 0 0", done_cnt - d0, req_rises - r0); end
    n_tests++; if (bus.x_flat !== '0) begin n_fail++; $display("FAIL mid_x_hold: got %h expected 0", bus.x_flat); end
  endtask

  task automatic test_ignored();
    bit ok;
    int reqs, dones;
    logic signed [W-1:0] g;
    apply_reset();
    for (int c = 0; c < N; c++) do_init(c, W'($urandom_range(5000, 0)));
    use_fixed = 0;
    run(3, $urandom_range(15, 0), 0, 2, 1, 0, '0, ok, reqs, dones);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: run did not complete"); end
    n_tests++; if (reqs !== 3) begin n_fail++; $display("FAIL ign_reqs: got %0d expected 3", reqs); end
    n_tests++; if (bus.step_count !== 16'd3) begin n_fail++; $display("FAIL ign_step: got %0d expected 3", bus.step_count); end
    n_tests++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done: got %0d expected 1", dones); end
    for (int c = 0; c < N; c++) begin
      g = bus.x_flat[c*W +: W];
      n_tests++; if (g !== W'(m_x[c])) begin n_fail++; $display("FAIL ign_x%0d: got %0d expected %0d", c, g, m_x[c]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int reqs, dones, ns;
    logic signed [W-1:0] g;
    apply_reset();
    use_fixed = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(1, 0) == 1) do_init(c, W'($urandom));
      ns = $urandom_range(4, 1);
      run(ns, $urandom_range(15, 0), 0, 3, 0, 0, '0, ok, reqs, dones);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_timeout: run did not complete", r); end
      for (int c = 0; c < N; c++) begin
        g = bus.x_flat[c*W +: W];
        n_tests++; if (g !== W'(m_x[c])) begin n_fail++; $display("FAIL rnd%0d_x%0d: got %0d expected %0d", r, c, g, m_x[c]); end
      end
      n_tests++; if (bus.step_count !== SW'(ns) || reqs !== ns || dones !== 1) begin n_fail++; $display("FAIL rnd%0d_counts: got step=%0d req=%0d done=%0d expected %0d %0d 1", r, bus.step_count, reqs, dones, ns, ns); end
      n_tests++; if (bus.sat_flag !== m_sat) begin n_fail++; $display("FAIL rnd%0d_sat: got %b expected %b", r, bus.sat_flag, m_sat); end
    end
  endtask

  initial begin
    bus.dt = '0;
    bus.init_we = 0;
    bus.init_ch = '0;
    bus.init_val = '0;
    bus.start = 0;
    bus.nsteps = '0;
    bus.func_valid = 0;
    bus.func_flat = '0;
    use_fixed = 0;
    test_reset();
    test_single_step();
    test_latency();
    test_neg_deriv();
    test_saturation();
    test_zero_steps();
    test_reset_midrun();
    test_ignored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
